// File: rtl/rf_write_arbiter_if.sv
// Requester, clear-control and register-file write-port signals of rf_write_arbiter.
interface rf_write_arbiter_if;
    localparam int unsigned DW = 16;
    localparam int unsigned AW = 3;

    logic          a_req;
    logic [AW-1:0] a_adr;
    logic [DW-1:0] a_data;
    logic          a_ack;
    logic          b_req;
    logic [AW-1:0] b_adr;
    logic [DW-1:0] b_data;
    logic          b_ack;
    logic          clr_start;
    logic          busy;
    logic          clr_done;
    logic [DW-1:0] W;
    logic [AW-1:0] W_Adr;
    logic          we_pulse;

    // Arbiter side
    modport slave (
        input  a_req, a_adr, a_data, b_req, b_adr, b_data, clr_start,
        output a_ack, b_ack, busy, clr_done, W, W_Adr, we_pulse
    );

    // Requester / control side
    modport master (
        output a_req, a_adr, a_data, b_req, b_adr, b_data, clr_start,
        input  a_ack, b_ack, busy, clr_done, W, W_Adr, we_pulse
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter for the register file's single write port, with an
// eight-write sequenced clear of R0..R7.
module rf_write_arbiter #(
    parameter bit ZERO_R0 = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    rf_write_arbiter_if.slave   bus
);
    localparam int unsigned DW = 16;
    localparam int unsigned AW = 3;
    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    typedef enum logic {IDLE, CLEAR} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;       // address of the clear write now on the port
    logic          last_q, last_d;
    logic [DW-1:0] w_q, w_d;
    logic [AW-1:0] w_adr_q, w_adr_d;
    logic          we_q, we_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          arb_en;
    logic          grant_a;
    logic          grant_b;

    // Grants depend only on req, state and last; forced low in reset and while a clear starts
    always_comb begin
        arb_en  = reset && (state_q == IDLE) && !bus.clr_start;
        grant_a = arb_en && bus.a_req && (!bus.b_req || (last_q == SEL_B));
        grant_b = arb_en && bus.b_req && (!bus.a_req || (last_q == SEL_A));
    end

    assign bus.a_ack    = grant_a;
    assign bus.b_ack    = grant_b;
    assign bus.W        = w_q;
    assign bus.W_Adr    = w_adr_q;
    assign bus.we_pulse = we_q;
    assign bus.busy     = busy_q;
    assign bus.clr_done = done_q;

    // Next-state and registered write-port values
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        w_d     = w_q;
        w_adr_d = w_adr_q;
        we_d    = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.clr_start) begin
                    // The R0 clear write is registered on the same edge that enters CLEAR
                    state_d = CLEAR;
                    cnt_d   = AW'(0);
                    w_d     = DW'(0);
                    w_adr_d = AW'(0);
                    we_d    = 1'b1;
                    busy_d  = 1'b1;
                end else if (grant_a) begin
                    last_d = SEL_A;
                    if (!(ZERO_R0 && (bus.a_adr == AW'(0)))) begin
                        w_d     = bus.a_data;
                        w_adr_d = bus.a_adr;
                        we_d    = 1'b1;
                    end
                end else if (grant_b) begin
                    last_d = SEL_B;
                    if (!(ZERO_R0 && (bus.b_adr == AW'(0)))) begin
                        w_d     = bus.b_data;
                        w_adr_d = bus.b_adr;
                        we_d    = 1'b1;
                    end
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == AW'(7)) begin
                    // R7 write is on the port this cycle; counter wraps to 0
                    state_d = IDLE;
                end else begin
                    w_d     = DW'(0);
                    w_adr_d = cnt_q + AW'(1);
                    we_d    = 1'b1;
                    busy_d  = 1'b1;
                    done_d  = (cnt_q == AW'(6));
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= AW'(0);
            last_q  <= SEL_B;
            w_q     <= DW'(0);
            w_adr_q <= AW'(0);
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            w_q     <= w_d;
            w_adr_q <= w_adr_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the register file's single write port (W, W_Adr, we_pulse) between two writeback requesters, A and B. Arbitration is round-robin. The block also provides a sequenced clear that zeroes R0–R7 on command. It sits between the CPU datapath writeback sources (for example ALU result and memory load) and the eight-register file. Its outputs are registered and connect directly to the file's write inputs.

## Interface
- ZERO_R0, default 0: when 1, requester writes to address 0 are acknowledged but not performed (R0 stays hard zero). Clear writes to R0 are always performed.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- a_req  in  1  requester A wants a write; held with a_adr/a_data until acknowledged.
- a_adr  in  3  destination register for A.
- a_data  in  16  write data for A.
- a_ack  out  1  combinational; A's request is accepted this cycle.
- b_req, b_adr, b_data, b_ack: same as the A signals, for requester B.
- clr_start  in  1  one-cycle pulse; start the clear sequence.
- busy  out  1  clear sequence in progress.
- clr_done  out  1  one-cycle pulse on the final clear write.
- W  out  16  register-file write data, registered.
- W_Adr  out  3  register-file write address, registered.
- we_pulse  out  1  register-file write enable, registered; high for exactly one cycle per write.

## Operation
- States: IDLE and CLEAR. A 3-bit clear counter and a 1-bit last-served pointer (last).
- While reset is low:
  - state = IDLE, counter = 0, last = B (so A wins the first tie).
  - W = 0, W_Adr = 0, we_pulse = 0, busy = 0, clr_done = 0.
  - a_ack = b_ack = 0, forced.
- IDLE, clr_start = 0 (arbitration):
  - Only one requester active: it is granted.
  - Both active: the requester that is not `last` is granted.
  - Grant raises that requester's ack in the same cycle.
  - At the next edge: W/W_Adr load the winner's data and address, we_pulse = 1, and last = winner.
  - Neither active: we_pulse = 0 at the next edge; W and W_Adr hold.
- The requester may change req, adr and data at the edge that ends its ack cycle. A req still high after that edge counts as a new request.
- ZERO_R0 = 1 and the granted adr = 0:
  - The ack and the last update happen normally.
  - we_pulse stays 0; W and W_Adr hold.
- clr_start = 1 in IDLE:
  - Both acks are 0 that cycle; clear takes priority over pending requests.
  - At the edge: state becomes CLEAR and counter = 0.
- CLEAR:
  - Each cycle registers W = 0x0000, W_Adr = counter, we_pulse = 1, then counter increments.
  - After the write with counter = 7: state returns to IDLE and the counter wraps to 0.
  - Acks are 0 throughout. clr_start is ignored, with no restart and no extension.
- Pending requests simply wait and are served round-robin after CLEAR. Requests are never dropped.
- Reset asserted mid-CLEAR: the sequence is abandoned immediately and all outputs go to their reset values. It does not resume after reset.

## Timing
- Request to write: ack in cycle t; we_pulse/W/W_Adr valid in cycle t+1; the file loads at the end of t+1.
- Throughput: one write per cycle. Requests on consecutive cycles give back-to-back we_pulse.
- Sustained dual requests alternate A, B, A, B.
- Clear: clr_start sampled high at edge k.
  - busy = 1 in cycles k+1 … k+8.
  - we_pulse = 1 with W_Adr = 0 … 7 in cycles k+1 … k+8.
  - clr_done = 1 in cycle k+8 only.
  - busy = 0 in cycle k+9.
- The earliest requester ack after a clear is cycle k+9, so its write appears in k+10.
- Acks are combinational from req, state and last only. No path from adr or data to the acks.

## Test plan
- Reset, then single request: release reset; A drives a_req=1, a_adr=3, a_data=0x1234 for one cycle.
  - Required: a_ack=1 that cycle.
  - Next cycle: we_pulse=1, W_Adr=3, W=0x1234.
  - Following cycle: we_pulse=0.
- Contention: A and B both hold req for 4 cycles (A adr 1 data 0xAAAA, B adr 2 data 0x5555).
  - Grants go A, B, A, B.
  - Writes alternate W_Adr 1/2 with the matching data on consecutive cycles.
- Clear with pending traffic: pulse clr_start while b_req=1 is held.
  - Required: b_ack=0 for 9 cycles; busy high for 8 cycles; W_Adr counts 0…7 with W=0; clr_done pulses on the adr 7 write.
  - Then b_ack=1 and B's write follows.
- clr_start during CLEAR: pulse clr_start again at the third clear write.
  - Required: exactly 8 clear writes in total; busy drops on schedule.
- ZERO_R0=1: A writes adr 0, data 0xFFFF.
  - Required: a_ack=1 and we_pulse stays 0.
  - A next write to adr 5 proceeds normally.
  - Repeat with ZERO_R0=0: we_pulse=1 with W_Adr=0.
- Reset mid-clear: assert reset during the fourth clear write.
  - Required: we_pulse, busy, clr_done and W drop to 0 immediately.
  - After release: state is IDLE, and a tie is granted to A.
